// File: rtl/idct_transpose_4x4.sv
// 4x4 transpose buffer between the row and column passes of the 4-point IDCT.
// Define IDCT_TR_PINGPONG_EN for a double-buffered build that streams one sample per cycle.
module idct_transpose_4x4 #(
    parameter int W     = 25,
    parameter int SAT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] d_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] d_out_1,
    output logic [W-1:0] d_out_2,
    output logic [W-1:0] d_out_3,
    output logic [W-1:0] d_out_4,
    output logic [1:0]   out_col,
    output logic         out_last
);

    localparam int EXT_W = W - SAT_W;

    logic [SAT_W-1:0] sat_in;
    logic [SAT_W-1:0] rd_word [4];
    logic [1:0]       wr_row;
    logic [1:0]       wr_col;
    logic [1:0]       rd_col;
    logic             in_fire;
    logic             out_fire;
    logic             wr_last;
    logic             rd_last;

    // The sample fits in SAT_W bits only when every bit above the SAT_W sign bit matches it.
    // NOTE: default assignment first so no path through always_comb leaves sat_in unassigned (no latch).
    always_comb begin
        sat_in = d_in[SAT_W-1:0];
        if (d_in[W-1:SAT_W-1] != {(EXT_W + 1){d_in[W-1]}}) begin
            sat_in = d_in[W-1] ? {1'b1, {(SAT_W-1){1'b0}}} : {1'b0, {(SAT_W-1){1'b1}}};
        end
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign wr_last  = (wr_row == 2'd3) && (wr_col == 2'd3);
    assign rd_last  = (rd_col == 2'd3);

    // Write and read pointers wrap naturally, so a completed block leaves them back at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_row <= 2'd0;
            wr_col <= 2'd0;
            rd_col <= 2'd0;
        end else begin
            if (in_fire) begin
                wr_col <= wr_col + 2'd1;
                if (wr_col == 2'd3) begin
                    wr_row <= wr_row + 2'd1;
                end
            end
            if (out_fire) begin
                rd_col <= rd_col + 2'd1;
            end
        end
    end

`ifdef IDCT_TR_PINGPONG_EN

    logic [SAT_W-1:0] bank [2][4][4];
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;

    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];

    // A bank completing on the write side and the other draining on the read side touch different flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            // NOTE: the storage is cleared on purpose so d_out_* read 0 after reset; data arrays are normally left unreset.
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        bank[b][r][c] <= '0;
                    end
                end
            end
        end else begin
            if (in_fire) begin
                bank[wr_bank][wr_row][wr_col] <= sat_in;
                if (wr_last) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= !wr_bank;
                end
            end
            if (out_fire && rd_last) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= !rd_bank;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_word[k] = bank[rd_bank][k][rd_col];
        end
    end

`else

    localparam logic FILL  = 1'b0;
    localparam logic DRAIN = 1'b1;

    logic [SAT_W-1:0] bank [4][4];
    logic             state;

    assign in_ready  = (state == FILL);
    assign out_valid = (state == DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    bank[r][c] <= '0;
                end
            end
        end else begin
            if (in_fire) begin
                bank[wr_row][wr_col] <= sat_in;
            end
            case (state)
                FILL:    if (in_fire && wr_last) state <= DRAIN;
                DRAIN:   if (out_fire && rd_last) state <= FILL;
                default: state <= FILL;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_word[k] = bank[k][rd_col];
        end
    end

`endif

    assign d_out_1  = {{EXT_W{rd_word[0][SAT_W-1]}}, rd_word[0]};
    assign d_out_2  = {{EXT_W{rd_word[1][SAT_W-1]}}, rd_word[1]};
    assign d_out_3  = {{EXT_W{rd_word[2][SAT_W-1]}}, rd_word[2]};
    assign d_out_4  = {{EXT_W{rd_word[3][SAT_W-1]}}, rd_word[3]};
    assign out_col  = rd_col;
    assign out_last = out_valid && rd_last;

endmodule

// File: tb/tb_idct_transpose_4x4.sv
// Scoreboard bench for idct_transpose_4x4; expected columns are queued as blocks are sent.
`timescale 1ns/1ps
module tb_idct_transpose_4x4;

    localparam int W     = 25;
    localparam int SAT_W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] d_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d_out_1;
    logic [W-1:0] d_out_2;
    logic [W-1:0] d_out_3;
    logic [W-1:0] d_out_4;
    logic [1:0]   out_col;
    logic         out_last;

    typedef struct packed {
        logic [3:0][W-1:0] d;
        logic [1:0]        col;
    } col_t;

    col_t sb[$];
    col_t mon_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stalls   = 0;
    int   blk[16];

    always #5 clk = ~clk;

    idct_transpose_4x4 #(.W(W), .SAT_W(SAT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .d_in     (d_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d_out_1  (d_out_1),
        .d_out_2  (d_out_2),
        .d_out_3  (d_out_3),
        .d_out_4  (d_out_4),
        .out_col  (out_col),
        .out_last (out_last)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sat_model(input int v);
        int r;
        r = v;
        if (v > 32767) r = 32767;
        else if (v < -32768) r = -32768;
        return W'(r);
    endfunction

    task automatic push_block(input int v[16]);
        col_t e;
        for (int c = 0; c < 4; c++) begin
            e.col = 2'(c);
            for (int k = 0; k < 4; k++) begin
                e.d[k] = sat_model(v[4*k + c]);
            end
            sb.push_back(e);
        end
    endtask

    // Leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send(input int v);
        int n;
        n = 0;
        in_valid = 1'b1;
        d_in     = W'(v);
        @(negedge clk);
        while (!in_ready) begin
            stalls++;
            n++;
            if (n > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, expected 1", n);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (sb.size() != 0 || out_valid) begin
            n++;
            if (n > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: %0d columns still pending, expected 0", sb.size());
                sb.delete();
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transferred column is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_column: out_col=%0d d_out_1=%0h, no column expected", out_col, d_out_1);
            end else begin
                mon_exp = sb.pop_front();
                check("col_index", out_col, mon_exp.col);
                check("col_row0", d_out_1, mon_exp.d[0]);
                check("col_row1", d_out_2, mon_exp.d[1]);
                check("col_row2", d_out_3, mon_exp.d[2]);
                check("col_row3", d_out_4, mon_exp.d[3]);
                check("col_last", out_last, mon_exp.col == 2'd3);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        d_in      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_d_out_1", d_out_1, '0);
        check("rst_d_out_4", d_out_4, '0);
        check("rst_out_col", out_col, 2'd0);
        check("rst_out_last", out_last, 1'b0);
        @(posedge clk);
        #1;

        // Fill 0..15 with first-column latency
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = i;
        push_block(blk);
        for (int i = 0; i < 15; i++) send(blk[i]);
        in_valid = 1'b1;
        d_in     = W'(15);
        @(negedge clk);
        check("latency_before_last", out_valid, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_valid_rises", out_valid, 1'b1);
        check("latency_first_col", out_col, 2'd0);
`ifdef IDCT_TR_PINGPONG_EN
        check("ready_after_fill", in_ready, 1'b1);
`else
        check("ready_after_fill", in_ready, 1'b0);
`endif
        wait_drain();

        // Saturation
        for (int i = 0; i < 16; i++) blk[i] = 0;
        blk[0] = 40000;
        blk[1] = -40000;
        blk[2] = 32767;
        blk[3] = -32768;
        push_block(blk);
        for (int i = 0; i < 16; i++) send(blk[i]);
        in_valid = 1'b0;
        wait_drain();

        // Backpressure on column 1
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) blk[i] = 1000 + 3*i;
        push_block(blk);
        for (int i = 0; i < 16; i++) send(blk[i]);
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 50) begin
                n++;
                @(negedge clk);
            end
            check("bp_valid_seen", out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_col", out_col, 2'd1);
            check("bp_hold_row0", d_out_1, sat_model(blk[1]));
            check("bp_hold_row1", d_out_2, sat_model(blk[5]));
            check("bp_hold_row2", d_out_3, sat_model(blk[9]));
            check("bp_hold_row3", d_out_4, sat_model(blk[13]));
        end
        @(posedge clk);
        #1;
        wait_drain();

`ifndef IDCT_TR_PINGPONG_EN
        // Input offered during DRAIN must be ignored
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) blk[i] = -50 * i;
        push_block(blk);
        for (int i = 0; i < 16; i++) send(blk[i]);
        in_valid = 1'b1;
        d_in     = W'(999);
        repeat (3) begin
            @(negedge clk);
            check("drain_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();
`endif

        // Reset mid-block discards the partial block
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(500 + i);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) blk[i] = 100 + i;
        push_block(blk);
        for (int i = 0; i < 15; i++) send(blk[i]);
        in_valid = 1'b1;
        d_in     = W'(115);
        @(negedge clk);
        check("mid_rst_no_early_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // Throughput: three blocks with in_valid held high
        stalls    = 0;
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = 2000 + 16*b + i;
            push_block(blk);
            for (int i = 0; i < 16; i++) send(blk[i]);
        end
        in_valid = 1'b0;
`ifdef IDCT_TR_PINGPONG_EN
        check("throughput_stalls", W'(stalls), W'(0));
`else
        check("throughput_stalls", W'(stalls), W'(8));
`endif
        wait_drain();

        check("final_queue_empty", W'(sb.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
